// File: rtl/safe_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : safe_access_arbiter
// Purpose  : Round-robin arbiter sharing one safe lock between N_REQ
//            requesters, with bounded unlock window and failure lockout.
//            Optional macro SAFE_ARB_STATS_EN builds attempt/unlock counters.
// Revision : 1.0 - initial release
// ============================================================================
module safe_access_arbiter #(
  parameter int N_REQ          = 2,
  parameter int RESP_WAIT      = 4,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 16,
  localparam int IDW           = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [32*N_REQ-1:0]  req_code,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 resp_valid,
  output logic [IDW-1:0]       resp_id,
  output logic                 resp_ok,
  output logic                 locked_out,
  output logic                 safe_rst,
  output logic [7:0]           safe_din,
  output logic                 safe_din_valid,
  input  logic                 safe_unlocked,
  output logic [15:0]          stat_attempts,
  output logic [15:0]          stat_unlocks
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_SEND    = 3'd2,
    S_WAIT    = 3'd3,
    S_RESP    = 3'd4,
    S_LOCKOUT = 3'd5
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_q, rr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [31:0]    code_q, code_d;
  logic [3:0]     fails_q, fails_d;
  logic [1:0]     byte_q, byte_d;
  logic [3:0]     wait_q, wait_d;
  logic [7:0]     lock_q, lock_d;
  logic           ok_q, ok_d;
  logic [7:0]     din_q, din_d;

  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] cand;
  logic [7:0]     cur_byte;

  // Winner is the first pending requester at or above rr_q, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = IDW'((int'(rr_q) + i) % N_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_comb begin
    case (byte_q)
      2'd0:    cur_byte = code_q[31:24];
      2'd1:    cur_byte = code_q[23:16];
      2'd2:    cur_byte = code_q[15:8];
      default: cur_byte = code_q[7:0];
    endcase
  end

  always_comb begin
    state_d        = state_q;
    rr_d           = rr_q;
    id_d           = id_q;
    code_d         = code_q;
    fails_d        = fails_q;
    byte_d         = byte_q;
    wait_d         = wait_q;
    lock_d         = lock_q;
    ok_d           = ok_q;
    din_d          = din_q;
    req_ready      = '0;
    resp_valid     = 1'b0;
    resp_id        = '0;
    resp_ok        = 1'b0;
    locked_out     = 1'b0;
    safe_rst       = 1'b0;
    safe_din_valid = 1'b0;
    safe_din       = din_q;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          for (int g = 0; g < N_REQ; g++) begin
            req_ready[g] = (win_id == IDW'(g));
          end
          code_d  = req_code[32*int'(win_id) +: 32];
          id_d    = win_id;
          rr_d    = IDW'((int'(win_id) + 1) % N_REQ);
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        safe_rst = 1'b1;
        byte_d   = 2'd0;
        ok_d     = 1'b0;
        state_d  = S_SEND;
      end
      S_SEND: begin
        safe_din_valid = 1'b1;
        safe_din       = cur_byte;
        din_d          = cur_byte;
        byte_d         = byte_q + 2'd1;
        if (byte_q == 2'd3) begin
          wait_d  = 4'd0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (safe_unlocked) begin
          ok_d    = 1'b1;
          state_d = S_RESP;
        end else if (wait_q == 4'(RESP_WAIT - 1)) begin
          ok_d    = 1'b0;
          state_d = S_RESP;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_id    = id_q;
        resp_ok    = ok_q;
        state_d    = S_IDLE;
        if (ok_q) begin
          fails_d = 4'd0;
        end else if (({1'b0, fails_q} + 5'd1) == 5'(MAX_FAILS)) begin
          fails_d = 4'd0;
          lock_d  = 8'(LOCKOUT_CYCLES - 1);
          state_d = S_LOCKOUT;
        end else begin
          fails_d = fails_q + 4'd1;
        end
      end
      S_LOCKOUT: begin
        locked_out = 1'b1;
        if (lock_q == 8'd0) begin
          state_d = S_IDLE;
        end else begin
          lock_d = lock_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Grants are combinational from req_valid, so mask them while reset is held.
    if (reset) begin
      req_ready = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      code_q  <= '0;
      fails_q <= '0;
      byte_q  <= '0;
      wait_q  <= '0;
      lock_q  <= '0;
      ok_q    <= 1'b0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      code_q  <= code_d;
      fails_q <= fails_d;
      byte_q  <= byte_d;
      wait_q  <= wait_d;
      lock_q  <= lock_d;
      ok_q    <= ok_d;
      din_q   <= din_d;
    end
  end

`ifdef SAFE_ARB_STATS_EN
  logic [15:0] att_q, att_d;
  logic [15:0] unl_q, unl_d;

  always_comb begin
    att_d = att_q;
    unl_d = unl_q;
    if (resp_valid && (att_q != 16'hFFFF)) begin
      att_d = att_q + 16'd1;
    end
    if (resp_valid && resp_ok && (unl_q != 16'hFFFF)) begin
      unl_d = unl_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      att_q <= '0;
      unl_q <= '0;
    end else begin
      att_q <= att_d;
      unl_q <= unl_d;
    end
  end

  assign stat_attempts = att_q;
  assign stat_unlocks  = unl_q;
`else
  assign stat_attempts = 16'd0;
  assign stat_unlocks  = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_safe_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_safe_access_arbiter
// Purpose  : Self-checking bench for safe_access_arbiter with a behavioural
//            safe and a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_safe_access_arbiter;

  localparam int N  = 2;
  localparam int RW = 4;
  localparam int MF = 3;
  localparam int LC = 16;
`ifdef SAFE_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [31:0]     codes [N];
  logic [32*N-1:0] req_code;
  logic [N-1:0]    req_ready;
  logic            resp_valid;
  logic [0:0]      resp_id;
  logic            resp_ok;
  logic            locked_out;
  logic            safe_rst;
  logic [7:0]      safe_din;
  logic            safe_din_valid;
  logic            safe_unlocked;
  logic [15:0]     stat_attempts;
  logic [15:0]     stat_unlocks;

  int checks = 0;
  int errors = 0;

  // reference-model state
  int m_rr    = 0;
  int m_fails = 0;
  int m_att   = 0;
  int m_unl   = 0;

  // behavioural safe
  logic [31:0] pw;
  int          sdel;
  logic [23:0] sbuf;
  int          scnt;
  bit          smatch;
  int          sage;

  always #5 clk = ~clk;

  always_comb begin
    for (int g = 0; g < N; g++) req_code[32*g +: 32] = codes[g];
  end

  safe_access_arbiter #(
    .N_REQ(N), .RESP_WAIT(RW), .MAX_FAILS(MF), .LOCKOUT_CYCLES(LC)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_code(req_code),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_ok(resp_ok), .locked_out(locked_out), .safe_rst(safe_rst),
    .safe_din(safe_din), .safe_din_valid(safe_din_valid),
    .safe_unlocked(safe_unlocked), .stat_attempts(stat_attempts),
    .stat_unlocks(stat_unlocks)
  );

  // Safe opens sdel cycles after a matching fourth byte.
  always @(posedge clk or posedge reset) begin
    if (reset || safe_rst) begin
      sbuf <= '0; scnt <= 0; smatch <= 1'b0; sage <= 0;
    end else if (safe_din_valid) begin
      sbuf <= {sbuf[15:0], safe_din};
      scnt <= scnt + 1;
      if (scnt == 3 && {sbuf, safe_din} == pw) begin
        smatch <= 1'b1;
        sage   <= 0;
      end
    end else if (smatch && sage < 1000) begin
      sage <= sage + 1;
    end
  end
  assign safe_unlocked = smatch && (sage >= sdel);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] m, input int rr);
    for (int i = 0; i < N; i++) if (m[(rr + i) % N]) return (rr + i) % N;
    return -1;
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ready"}, {30'd0, req_ready}, 0);
    chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 0);
    chk({tag, "_resp_id"}, {31'd0, resp_id}, 0);
    chk({tag, "_resp_ok"}, {31'd0, resp_ok}, 0);
    chk({tag, "_locked"}, {31'd0, locked_out}, 0);
    chk({tag, "_safe_rst"}, {31'd0, safe_rst}, 0);
    chk({tag, "_din"}, {24'd0, safe_din}, 0);
    chk({tag, "_din_valid"}, {31'd0, safe_din_valid}, 0);
  endtask

  // One arbitration round: grant, clear, four bytes, response, optional lockout.
  task automatic attempt(input logic [N-1:0] mask, input int del, input bit hold);
    int          win, exp_lat, lat;
    bit          exp_ok;
    logic [N-1:0] oh;
    logic [31:0] code;
    win    = pick(mask, m_rr);
    code   = codes[win];
    exp_ok = (code == pw) && (del < RW);
    exp_lat = exp_ok ? 7 + del : 6 + RW;
    oh     = '0;
    oh[win] = 1'b1;
    sdel   = del;

    @(negedge clk); req_valid = mask; #1;
    chk("not_locked", {31'd0, locked_out}, 0);
    chk("grant", {30'd0, req_ready}, {30'd0, oh});
    m_rr = (win + 1) % N;

    @(negedge clk); if (!hold) req_valid = '0; #1;
    chk("clear_rst", {31'd0, safe_rst}, 1);
    chk("clear_ready", {30'd0, req_ready}, 0);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk); #1;
      chk("send_valid", {31'd0, safe_din_valid}, 1);
      chk("send_byte", {24'd0, safe_din}, {24'd0, code[31-8*b -: 8]});
    end

    lat = -1;
    for (int c = 6; c <= 8 + RW; c++) begin
      if (lat < 0) begin
        @(negedge clk); #1;
        if (resp_valid) begin
          lat = c;
          chk("resp_id", {31'd0, resp_id}, win);
          chk("resp_ok", {31'd0, resp_ok}, {31'd0, exp_ok});
        end else begin
          chk("wait_din_valid", {31'd0, safe_din_valid}, 0);
          chk("wait_din_hold", {24'd0, safe_din}, {24'd0, code[7:0]});
        end
      end
    end
    chk("resp_latency", lat, exp_lat);

    m_att++;
    if (exp_ok) begin
      m_unl++;
      m_fails = 0;
    end else begin
      m_fails++;
      if (m_fails == MF) begin
        m_fails = 0;
        for (int i = 0; i < LC; i++) begin
          @(negedge clk); req_valid = (i < LC - 1) ? '1 : '0; #1;
          chk("lockout_flag", {31'd0, locked_out}, 1);
          chk("lockout_ready", {30'd0, req_ready}, 0);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0;
    pw = 32'hbaadc0de;
    sdel = 0;
    for (int g = 0; g < N; g++) codes[g] = '0;

    repeat (2) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    chk("reset_stat_att", {16'd0, stat_attempts}, 0);
    chk("reset_stat_unl", {16'd0, stat_unlocks}, 0);
    @(negedge clk); reset = 1'b0;

    // both requesters held from the same cycle: grants alternate 0,1,0,1
    codes[0] = pw; codes[1] = pw;
    for (int k = 0; k < 4; k++) attempt(2'b11, 0, 1'b1);

    // directed correct code
    attempt(2'b01, 0, 1'b0);

    // three wrong codes trigger lockout, then a correct code succeeds
    codes[0] = 32'h0000_0000;
    for (int k = 0; k < 3; k++) attempt(2'b01, 0, 1'b0);
    codes[0] = pw;
    attempt(2'b01, 1, 1'b0);

    // two wrong, one right, two wrong: counter clears, no lockout
    codes[1] = 32'h0000_0000;
    attempt(2'b10, 0, 1'b0);
    attempt(2'b10, 0, 1'b0);
    codes[1] = pw;
    attempt(2'b10, RW - 1, 1'b0);
    codes[1] = 32'h1234_5678;
    attempt(2'b10, 0, 1'b0);
    attempt(2'b10, 0, 1'b0);
    codes[1] = pw;
    attempt(2'b10, RW, 1'b0);   // correct code but too slow: counts as third fail

    // randomized rounds
    for (int k = 0; k < 14; k++) begin
      for (int g = 0; g < N; g++) codes[g] = ($urandom_range(0, 1) != 0) ? pw : $urandom;
      attempt(N'($urandom_range(1, (1 << N) - 1)), int'($urandom_range(0, RW + 1)), 1'b0);
    end

    // reset during SEND after the second byte
    codes[0] = pw;
    sdel = 0;
    @(negedge clk); req_valid = 2'b01; #1;
    chk("rst_grant", {30'd0, req_ready}, 1);
    @(negedge clk); req_valid = '0;
    @(negedge clk); #1;
    chk("rst_byte0", {24'd0, safe_din}, 32'hba);
    @(negedge clk); #1;
    chk("rst_byte1", {24'd0, safe_din}, 32'had);
    #1; reset = 1'b1; #1;
    check_idle_outputs("mid_reset");
    @(negedge clk); reset = 1'b0;
    m_rr = 0; m_fails = 0; m_att = 0; m_unl = 0;
    for (int i = 0; i < RW + 8; i++) begin
      @(negedge clk); #1;
      chk("no_resp_after_reset", {31'd0, resp_valid}, 0);
    end
    attempt(2'b01, 0, 1'b0);

    // 3 fails then 1 success since reset
    codes[0] = 32'h0;
    attempt(2'b01, 0, 1'b0);
    attempt(2'b01, 0, 1'b0);
    codes[1] = 32'hdead_beef;
    attempt(2'b10, 0, 1'b0);
    @(negedge clk); #1;
    chk("stat_attempts", {16'd0, stat_attempts}, STATS ? m_att : 0);
    chk("stat_unlocks", {16'd0, stat_unlocks}, STATS ? m_unl : 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/safe_access_arbiter.md
Name: safe_access_arbiter

Overview:
- Shares one `safe` lock instance between N_REQ requesters. Each requester submits a 32-bit code.
- The block grants requesters round-robin. For each granted request it clears the safe, streams the code MSB-first as four bytes on din/din_valid, then samples unlocked in a bounded window.
- Returns pass/fail and the requester ID.
- Enforces a global lockout after MAX_FAILS consecutive failed attempts.

Parameters:
- N_REQ, 2, number of requesters (1..8); IDW = (N_REQ>1) ? $clog2(N_REQ) : 1
- RESP_WAIT, 4, cycles unlocked is sampled after the last byte (1..15)
- MAX_FAILS, 3, consecutive failures that trigger lockout (1..15)
- LOCKOUT_CYCLES, 16, lockout duration in cycles (1..255)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; all state cleared immediately
- req_valid  in  N_REQ  per-requester request; held until accepted
- req_code  in  32*N_REQ  code for requester g at [32g+31:32g]
- req_ready  out  N_REQ  one-hot grant; transfer when req_valid[g]&req_ready[g]
- resp_valid  out  1  one-cycle result pulse
- resp_id  out  IDW  requester index of result
- resp_ok  out  1  1 = safe unlocked, valid with resp_valid
- locked_out  out  1  high during lockout
- safe_rst  out  1  reset to the safe instance
- safe_din  out  8  byte to the safe
- safe_din_valid  out  1  byte strobe to the safe
- safe_unlocked  in  1  safe's unlocked output

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE, rr pointer 0, fail counter 0.
  - Reset mid-attempt aborts it: no response is produced and the captured code is discarded.
- FSM states: IDLE, CLEAR, SEND, WAIT, RESP, LOCKOUT.
- IDLE:
  - If any req_valid is high, assert req_ready for exactly one winner, combinationally from registered state and req_valid.
  - Winner is the first set bit searching from rr_ptr upward with wrap.
  - On that cycle (T): capture the code and the ID, set rr_ptr = winner+1 mod N_REQ, go to CLEAR.
  - No request: stay in IDLE, rr_ptr unchanged.
- CLEAR (T+1): safe_rst=1 for exactly one cycle, then go to SEND.
- SEND (T+2..T+5):
  - safe_din_valid=1; safe_din = code[31:24], [23:16], [15:8], [7:0] in that order.
  - 2-bit byte index; the cycle with index 3 goes to WAIT.
  - safe_unlocked is ignored in SEND.
- WAIT (T+6 .. T+5+RESP_WAIT):
  - safe_din_valid=0; safe_din holds its last value.
  - Sample safe_unlocked each cycle. First 1 → ok=1 → RESP (early exit).
  - After RESP_WAIT samples with no 1 → ok=0 → RESP.
- RESP (one cycle): resp_valid=1 with the captured resp_id and ok.
  - ok=1: fail counter ← 0, go to IDLE.
  - ok=0, counter+1 < MAX_FAILS: counter increments, go to IDLE.
  - ok=0, counter+1 == MAX_FAILS: counter ← 0, go to LOCKOUT.
- LOCKOUT:
  - locked_out=1; req_ready all 0; exactly LOCKOUT_CYCLES cycles (8-bit down-counter).
  - Then go to IDLE; a pending request may be granted on the first IDLE cycle.
- req_ready is 0 in every state except IDLE; at most one requester is in flight.
- Best-case result latency: resp_valid at T+7 (unlock seen at first WAIT sample).
- Worst case: resp_valid at T+6+RESP_WAIT.
- Simultaneous requests: only the winner is granted; losers keep req_valid high and are served in rr order on later IDLE visits.
- A requester may withdraw req_valid before grant. It must not change req_code while req_valid is high and req_ready is low.

Optional Feature:
- Macro: SAFE_ARB_STATS_EN.
- Defined: adds outputs stat_attempts[15:0] and stat_unlocks[15:0].
  - Increment on each resp_valid, and on each resp_valid with resp_ok, respectively.
  - Saturate at 16'hFFFF; reset to 0.
- Not defined: both outputs exist but are tied to 0, and no counter registers are built.

Test Plan:
- Safe password 32'hbaadc0de, req0 code 32'hbaadc0de:
  - safe_rst pulse at T+1.
  - Bytes ba, ad, c0, de at T+2..T+5.
  - resp_valid with resp_id=0, resp_ok=1 within T+6+RESP_WAIT.
- req0 and req1 both valid from the same cycle after reset: req0 granted first, req1 granted on the next IDLE; then with both held, grants alternate 0,1,0,1.
- Three consecutive wrong codes (32'h00000000) with MAX_FAILS=3:
  - Three resp_ok=0 responses.
  - locked_out high for exactly 16 cycles with req_ready all 0.
  - Next correct code succeeds.
- Two wrong codes then one correct: fail counter clears, no lockout; two further wrong codes still do not lock out.
- reset asserted during SEND (after byte ad): outputs 0 immediately, no resp_valid; a re-issued request completes normally from CLEAR.
- With SAFE_ARB_STATS_EN: after 3 fails and 1 success, stat_attempts=4 and stat_unlocks=1; without the macro, both read 0.
